// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer between the load/store unit (port 0) and the
// loader/debug port (port 1) for the shared data memory. One transaction per 3 cycles.
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam int unsigned MEM_BYTES = 4 * MEM_WORDS;

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          port_q, port_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;
    logic          busy_q, busy_d;

    logic          sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_in_range;
    logic          rd_ok;

    // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
    assign sel          = req1 & (~req0 | ~last_grant_q);
    assign sel_we       = sel ? we1 : we0;
    assign sel_addr     = sel ? addr1 : addr0;
    assign sel_wdata    = sel ? wdata1 : wdata0;
    assign sel_in_range = (sel_addr < AW'(MEM_BYTES));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        oor_d        = oor_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = CMD;
                    port_d       = sel;
                    last_grant_d = sel;
                    we_d         = sel_we;
                    oor_d        = ~sel_in_range;
                    if (sel_in_range) begin
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        mem_read_d  = ~sel_we;
                        mem_write_d = sel_we;
                    end
                end
            end
            CMD: begin
                state_d = RESP;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                err0_d  = ~port_q & oor_q;
                err1_d  = port_q & oor_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            busy_q       <= busy_d;
        end
    end

    // Memory read data arrives registered in the RESP cycle, so it is gated rather than re-registered.
    assign rd_ok     = ~we_q & ~oor_q;
    assign rdata0    = (ack0_q && rd_ok) ? mem_rdata : '0;
    assign rdata1    = (ack1_q && rd_ok) ? mem_rdata : '0;

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-port reads/writes, range boundary,
// round-robin contention, mid-transaction reset and idle behaviour.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];

    dmem_arbiter #(.MEM_WORDS(4096), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory model: read data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[13:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[13:2]];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((mem_read & mem_write) !== 1'b0) begin
                bad++;
                $display("FAIL strobe_overlap: read=%b write=%b want not both", mem_read, mem_write);
            end
        end
    end

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, ack0, ack1, err0, err1, mem_read, mem_write, mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b ack=%b%b err=%b%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                     busy, ack0, ack1, err0, err1, mem_read, mem_write, mem_addr, mem_wdata);
        end
        rst_n = 1;
    endtask

    task automatic test_write_p1();
        req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({mem_write, mem_read, busy, mem_addr, mem_wdata} !== {3'b101, 32'h10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr1_cmd: wr=%b rd=%b busy=%b addr=%h wdata=%h want 1 0 1 00000010 deadbeef",
                     mem_write, mem_read, busy, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({ack1, err1, rdata1, ack0, mem_write} !== {2'b10, 32'h0, 2'b00}) begin
            bad++;
            $display("FAIL wr1_resp: ack1=%b err1=%b rdata1=%h ack0=%b wr=%b want 1 0 0 0 0",
                     ack1, err1, rdata1, ack0, mem_write);
        end
        clear_inputs();
        @(negedge clk);
        total++;
        if ({ack1, busy} !== 2'b00) begin
            bad++;
            $display("FAIL wr1_done: ack1=%b busy=%b want 0 0", ack1, busy);
        end
    endtask

    task automatic test_read_p0();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h10}) begin
            bad++;
            $display("FAIL rd0_cmd: rd=%b wr=%b addr=%h want 1 0 00000010", mem_read, mem_write, mem_addr);
        end
        @(negedge clk);
        total++;
        if ({ack0, err0, rdata0, ack1, rdata1} !== {2'b10, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL rd0_resp: ack0=%b err0=%b rdata0=%h ack1=%b rdata1=%h want 1 0 deadbeef 0 0",
                     ack0, err0, rdata0, ack1, rdata1);
        end
        clear_inputs();
        @(negedge clk);
        total++;
        if ({ack0, rdata0, busy} !== '0) begin
            bad++;
            $display("FAIL rd0_done: ack0=%b rdata0=%h busy=%b want 0 0 0", ack0, rdata0, busy);
        end
    endtask

    task automatic test_out_of_range();
        // Last valid word is in range.
        req0 = 1; we0 = 1; addr0 = 32'h3FFC; wdata0 = 32'hA5A5_0001;
        @(negedge clk);
        total++;
        if ({mem_write, mem_addr} !== {1'b1, 32'h3FFC}) begin
            bad++;
            $display("FAIL edge_cmd: wr=%b addr=%h want 1 00003ffc", mem_write, mem_addr);
        end
        @(negedge clk);
        total++;
        if ({ack0, err0} !== 2'b10) begin
            bad++;
            $display("FAIL edge_resp: ack0=%b err0=%b want 1 0", ack0, err0);
        end
        req0 = 1; we0 = 0; addr0 = 32'h4000; wdata0 = 32'h0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, busy} !== {2'b00, 64'h0, 1'b1}) begin
            bad++;
            $display("FAIL oor_cmd: rd=%b wr=%b addr=%h wdata=%h busy=%b want 0 0 0 0 1",
                     mem_read, mem_write, mem_addr, mem_wdata, busy);
        end
        @(negedge clk);
        total++;
        if ({ack0, err0, rdata0, ack1, err1} !== {2'b11, 32'h0, 2'b00}) begin
            bad++;
            $display("FAIL oor_resp: ack0=%b err0=%b rdata0=%h ack1=%b err1=%b want 1 1 0 0 0",
                     ack0, err0, rdata0, ack1, err1);
        end
        clear_inputs();
        @(negedge clk);
        total++;
        if ({ack0, err0, busy} !== 3'b000) begin
            bad++;
            $display("FAIL oor_done: ack0=%b err0=%b busy=%b want 0 0 0", ack0, err0, busy);
        end
    endtask

    task automatic test_contention();
        logic [12:0] e_ack0, e_ack1, e_wr;
        logic [31:0] e_addr;
        e_ack0 = 13'h104;
        e_ack1 = 13'h820;
        e_wr   = 13'h492;
        rst_n = 0;
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1111_0000;
        req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'h2222_0000;
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            e_addr = (i == 1 || i == 7) ? 32'h20 : (i == 4 || i == 10) ? 32'h24 : 32'h0;
            total++;
            if ({ack0, ack1, mem_write, mem_read, busy, mem_addr} !==
                {e_ack0[i], e_ack1[i], e_wr[i], 1'b0, (i % 3 != 0), e_addr}) begin
                bad++;
                $display("FAIL contend_cyc%0d: ack=%b%b wr=%b rd=%b busy=%b addr=%h want %b%b %b 0 %b %h",
                         i, ack0, ack1, mem_write, mem_read, busy, mem_addr,
                         e_ack0[i], e_ack1[i], e_wr[i], (i % 3 != 0), e_addr);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_cmd: wr=%b want 1", mem_write);
        end
        rst_n = 0;
        clear_inputs();
        #1;
        total++;
        if ({mem_write, busy, ack0, mem_addr} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: wr=%b busy=%b ack0=%b addr=%h want 0 0 0 0",
                     mem_write, busy, ack0, mem_addr);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, mem_write} !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_post%0d: ack=%b%b busy=%b wr=%b want 0", i, ack0, ack1, busy, mem_write);
            end
        end
    endtask

    task automatic test_idle();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({busy, mem_read, mem_write, ack0, ack1, mem_addr} !== '0) begin
                bad++;
                $display("FAIL idle%0d: busy=%b rd=%b wr=%b ack=%b%b addr=%h want 0",
                         i, busy, mem_read, mem_write, ack0, ack1, mem_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_p1();
        test_read_p0();
        test_out_of_range();
        test_contention();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared word-addressed data memory.
- Port 0 is the pipeline load/store unit; port 1 is the loader/debug port.
- Accepts one transaction at a time, grants round-robin and drives the memory command bus for exactly one cycle.
- Captures the registered memory read result and returns it with a one-cycle ack pulse, or flags out-of-range addresses without touching memory.

Parameters:
- MEM_WORDS, 4096: memory depth in 32-bit words; valid byte addresses are 0 to 4*MEM_WORDS-1.
- AW, 32: byte-address width on requester and memory ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request valid, port 0 / port 1; held with its fields until ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  32  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data, valid only while the matching ack is high; 0 otherwise.
- err0 / err1  out  1  out-of-range flag, valid only with the matching ack.
- mem_addr  out  AW  memory byte address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; registered, valid the cycle after mem_read.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM to IDLE, last_grant = 1 (so port 0 wins the first tie). Holds while low.
- FSM states: IDLE, CMD, RESP, all outputs registered.
- IDLE: if req0 or req1 is high, pick the winner and latch its we/addr/wdata and its port id; go to CMD. Otherwise stay in IDLE.
- Arbitration: if only one port requests, it wins. If both request, the port that is not last_grant wins. last_grant updates on the IDLE to CMD transition.
- Range check in IDLE: the request is in range iff addr < 4*MEM_WORDS.
- CMD, in range: drive mem_addr = latched address, mem_wdata = latched data, and exactly one of mem_read / mem_write high for this single cycle.
- CMD, out of range: no strobe, mem_addr = 0, mem_wdata = 0, err pending.
- CMD always goes to RESP.
- RESP: pulse ack of the granted port for one cycle.
  - Read, in range: rdata = mem_rdata, sampled this cycle.
  - Write, or out of range: rdata = 0.
  - err = 1 only when out of range.
  - Always return to IDLE.
- Latency: req sampled in IDLE at cycle T, strobe in T+1, ack in T+2. Back-to-back throughput is one transaction per 3 cycles.
- Requester contract: keep req and its fields stable until ack. Drop req, or present the next transaction, on the edge that ends the ack cycle. A req still high in IDLE is treated as a new request.
- A req deasserted before ack is a protocol violation. The arbiter ignores the drop and completes the latched transaction anyway.
- The non-granted port's ack, rdata and err stay 0 throughout.
- mem_addr is passed through as a byte address; the memory does its own word indexing from bits [13:2].
- Low address bits [1:0] are not checked.
- Strobes are never asserted together; mem_read and mem_write are 0 in IDLE and RESP.
- Reset mid-transaction: any strobe and ack drop immediately, nothing completes, and no ack is issued after reset release.

Test Plan:
- Port 1 write: req1, we1 = 1, addr1 = 0x10, wdata1 = 0xDEADBEEF → next cycle mem_write = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF; following cycle ack1 = 1, err1 = 0, rdata1 = 0.
- Port 0 read: req0, we0 = 0, addr0 = 0x10, memory model returns 0xDEADBEEF one cycle after mem_read → ack0 at T+2 with rdata0 = 0xDEADBEEF; ack1 stays 0.
- Simultaneous contention: both ports hold req continuously with distinct addresses from reset → grant order 0, 1, 0, 1; acks 3 cycles apart; no two strobes in one cycle.
- Out of range: req0 read at addr0 = 0x4000 (MEM_WORDS = 4096) → no mem_read/mem_write in CMD; ack0 = 1, err0 = 1, rdata0 = 0.
- Reset mid-transaction: assert rst_n low during CMD of a write → mem_write falls asynchronously, busy = 0; after release with no req, no ack for 5 cycles.
- Idle: no req for 10 cycles → busy = 0, all strobes and acks 0, mem_addr = 0.
